uart_apb_regs: RTL and testbench

//  APB3 completer (slave) end of the UART register interface: decodes PSEL/PENABLE/PWRITE/PADDR

---
 rtl/uart_apb_regs_pkg.sv | 59 +++++
 rtl/uart_apb_regs_if.sv | 21 ++
 rtl/uart_apb_regs_fifo.sv | 45 ++++
 rtl/uart_apb_regs.sv | 184 ++++++++++++++++++
 tb/tb_uart_apb_regs.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_apb_regs_pkg.sv
// Shared definitions for the UART APB register block: register map, bit indices, parity and read FSM
// encodings, and the optional peripheral/component ID words.
package uart_apb_regs_pkg;

    localparam logic [9:0] A_DATA    = 10'h000;
    localparam logic [9:0] A_STATUS  = 10'h001;
    localparam logic [9:0] A_CTRL    = 10'h002;
    localparam logic [9:0] A_INTSTAT = 10'h003;
    localparam logic [9:0] A_BAUDDIV = 10'h004;
    localparam logic [9:0] A_PARITY  = 10'h005;
    localparam logic [9:0] A_ID_BASE = 10'h3F8;

    localparam int CTRL_TXEN     = 0;
    localparam int CTRL_RXEN     = 1;
    localparam int CTRL_TXINT_EN = 2;
    localparam int CTRL_RXINT_EN = 3;
    localparam int CTRL_TXOVR_EN = 4;
    localparam int CTRL_RXOVR_EN = 5;

    localparam int INT_TX    = 0;
    localparam int INT_RX    = 1;
    localparam int INT_TXOVR = 2;
    localparam int INT_RXOVR = 3;

    localparam int ST_TX_FULL     = 0;
    localparam int ST_RX_NONEMPTY = 1;
    localparam int ST_TX_EMPTY    = 2;
    localparam int ST_RX_FULL     = 3;

    localparam logic [3:0] ID_REV = 4'h1;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_ODD  = 2'b01,
        PAR_EVEN = 2'b10,
        PAR_RSVD = 2'b11
    } parity_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RDWAIT = 2'd1,
        ST_RDDONE = 2'd2
    } rd_state_e;

    // PID0..PID3 then CID0..CID3; PID3 high nibble carries the ECO revision
    function automatic logic [7:0] id_word(input logic [2:0] idx, input logic [3:0] eco);
        case (idx)
            3'd0:    return 8'h11;
            3'd1:    return 8'h10;
            3'd2:    return {ID_REV, 4'h4};
            3'd3:    return {eco, 4'h0};
            3'd4:    return 8'h0D;
            3'd5:    return 8'hF0;
            3'd6:    return 8'h05;
            default: return 8'hB1;
        endcase
    endfunction

endpackage

// File: rtl/uart_apb_regs_if.sv
// APB3 completer bus bundle between the system bus and the UART register block.
interface uart_apb_regs_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [11:2] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/uart_apb_regs_fifo.sv
// Synchronous FIFO, head visible combinationally; push/pop take effect on the clock edge.
// Caller qualifies push/pop (no push when full unless popping, no pop when empty).
module uart_apb_regs_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [W-1:0]     din_i,
    input  logic             pop_i,
    output logic [W-1:0]     dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push_i) begin
                mem_q[wptr_q] <= din_i;
                wptr_q        <= wptr_q + PTR_W'(1);
            end
            if (pop_i) rptr_q <= rptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    assign dout_o  = mem_q[rptr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/uart_apb_regs.sv
// UART APB3 register block: zero-wait writes, one-wait-state reads, TX/RX byte FIFOs, sticky interrupts.
// UART_APB_REGS_ID_EN maps read-only ID words at PADDR 0x3F8..0x3FF; otherwise those addresses error.
module uart_apb_regs
    import uart_apb_regs_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int BAUD_W     = 20
) (
    input  logic              PCLK,
    input  logic              PRESET,
    uart_apb_regs_if.slave    apb,
    input  logic [3:0]        ECOREVNUM,
    output logic [7:0]        TXDATA,
    output logic              TXVALID,
    input  logic              TXREADY,
    input  logic [7:0]        RXDATA,
    input  logic              RXVALID,
    output logic [BAUD_W-1:0] BAUDDIV,
    output logic              TXEN,
    output logic              RXEN,
    output logic [1:0]        PARITY,
    output logic              TXINT,
    output logic              RXINT,
    output logic              TXOVRINT,
    output logic              RXOVRINT,
    output logic              UARTINT
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [6:0]        ctrl_q;
    logic [3:0]        intstat_q, intstat_d;
    logic [BAUD_W-1:0] baud_q;
    parity_e           parity_q;
    logic [3:0]        irq_q;
    logic              uartint_q;
    logic [31:0]       prdata_q;
    rd_state_e         state_q;

    logic              access, wr_acc, rd_cap;
    logic              addr_ok, baud_bad, wr_err;
    logic [31:0]       rdata;

    logic [7:0]        tx_dout, rx_dout;
    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic [CNT_W-1:0]  tx_count, rx_count;
    logic              tx_wr, tx_push, tx_pop, tx_ovr, tx_drain;
    logic              rx_in, rx_push, rx_pop, rx_ovr;
    logic [3:0]        int_en, intstat_set, intstat_clr;
    logic              unused_ok;

    assign access = apb.PSEL & apb.PENABLE;
    assign wr_acc = access & apb.PWRITE;
    // First access cycle of a read is the wait state; the second (RDDONE) completes it
    assign rd_cap = access & ~apb.PWRITE & (state_q != ST_RDDONE);

    always_comb begin
        addr_ok = 1'b1;
        rdata   = '0;
        case (apb.PADDR)
            A_DATA:    rdata = rx_empty ? 32'h0 : {24'h0, rx_dout};
            A_STATUS:  rdata = {24'h0, 4'(rx_count), rx_full, tx_empty, ~rx_empty, tx_full};
            A_CTRL:    rdata = {25'h0, ctrl_q};
            A_INTSTAT: rdata = {28'h0, intstat_q};
            A_BAUDDIV: rdata = 32'(baud_q);
            A_PARITY:  rdata = {30'h0, parity_q};
            default: begin
`ifdef UART_APB_REGS_ID_EN
                if (apb.PADDR >= A_ID_BASE) rdata = {24'h0, id_word(apb.PADDR[4:2], ECOREVNUM)};
                else addr_ok = 1'b0;
`else
                addr_ok = 1'b0;
`endif
            end
        endcase
    end

    assign baud_bad = apb.PWDATA[BAUD_W-1:0] < BAUD_W'(16);
    assign wr_err   = ~addr_ok | ((apb.PADDR == A_BAUDDIV) & baud_bad);

    assign apb.PREADY  = ~rd_cap;
    assign apb.PSLVERR = access & ~rd_cap & (apb.PWRITE ? wr_err : ~addr_ok);
    assign apb.PRDATA  = (access && state_q == ST_RDDONE) ? prdata_q : 32'h0;

    // A full FIFO that pops in the same cycle still accepts the push
    assign tx_pop   = TXVALID & TXREADY;
    assign tx_wr    = wr_acc & (apb.PADDR == A_DATA);
    assign tx_push  = tx_wr & (~tx_full | tx_pop);
    assign tx_ovr   = tx_wr & tx_full & ~tx_pop;
    assign tx_drain = tx_pop & ~tx_push & (tx_count == CNT_W'(1));

    assign rx_in   = RXVALID & ctrl_q[CTRL_RXEN];
    assign rx_pop  = rd_cap & (apb.PADDR == A_DATA) & ~rx_empty;
    assign rx_push = rx_in & (~rx_full | rx_pop);
    assign rx_ovr  = rx_in & rx_full & ~rx_pop;

    uart_apb_regs_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
        .clk_i   (PCLK),
        .rst_i   (PRESET),
        .push_i  (tx_push),
        .din_i   (apb.PWDATA[7:0]),
        .pop_i   (tx_pop),
        .dout_o  (tx_dout),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count)
    );

    uart_apb_regs_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
        .clk_i   (PCLK),
        .rst_i   (PRESET),
        .push_i  (rx_push),
        .din_i   (RXDATA),
        .pop_i   (rx_pop),
        .dout_o  (rx_dout),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count)
    );

    assign int_en      = {ctrl_q[CTRL_RXOVR_EN], ctrl_q[CTRL_TXOVR_EN],
                          ctrl_q[CTRL_RXINT_EN], ctrl_q[CTRL_TXINT_EN]};
    assign intstat_set = {rx_ovr, tx_ovr, rx_push, tx_drain};
    assign intstat_clr = (wr_acc && apb.PADDR == A_INTSTAT) ? apb.PWDATA[3:0] : 4'h0;
    assign intstat_d   = (intstat_q & ~intstat_clr) | intstat_set;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ctrl_q    <= '0;
            intstat_q <= '0;
            baud_q    <= '0;
            parity_q  <= PAR_NONE;
            irq_q     <= '0;
            uartint_q <= 1'b0;
            prdata_q  <= '0;
            state_q   <= ST_IDLE;
        end else begin
            if (wr_acc && apb.PADDR == A_CTRL) ctrl_q <= apb.PWDATA[6:0];
            if (wr_acc && apb.PADDR == A_BAUDDIV && !baud_bad) baud_q <= apb.PWDATA[BAUD_W-1:0];
            if (wr_acc && apb.PADDR == A_PARITY) parity_q <= parity_e'(apb.PWDATA[1:0]);
            intstat_q <= intstat_d;
            irq_q     <= intstat_q & int_en;
            uartint_q <= |(intstat_q & int_en);
            case (state_q)
                ST_IDLE: begin
                    if (rd_cap) begin
                        prdata_q <= rdata;
                        state_q  <= ST_RDDONE;
                    end else if (apb.PSEL && !apb.PENABLE && !apb.PWRITE) begin
                        state_q <= ST_RDWAIT;
                    end
                end
                ST_RDWAIT: begin
                    if (rd_cap) begin
                        prdata_q <= rdata;
                        state_q  <= ST_RDDONE;
                    end else if (!apb.PSEL) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RDDONE: begin
                    prdata_q <= '0;
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign TXDATA   = tx_dout;
    assign TXVALID  = ctrl_q[CTRL_TXEN] & ~tx_empty;
    assign BAUDDIV  = baud_q;
    assign TXEN     = ctrl_q[CTRL_TXEN];
    assign RXEN     = ctrl_q[CTRL_RXEN];
    assign PARITY   = (parity_q == PAR_RSVD) ? PAR_NONE : parity_q;
    assign TXINT    = irq_q[INT_TX];
    assign RXINT    = irq_q[INT_RX];
    assign TXOVRINT = irq_q[INT_TXOVR];
    assign RXOVRINT = irq_q[INT_RXOVR];
    assign UARTINT  = uartint_q;

    assign unused_ok = ^{ECOREVNUM, apb.PWDATA};

endmodule

// File: tb/tb_uart_apb_regs.sv
// Directed bench for uart_apb_regs: APB register access, TX/RX FIFO flow, interrupts and error responses.
module tb_uart_apb_regs;

    localparam int DEPTH  = 4;
    localparam int BAUD_W = 20;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic [3:0]        ECOREVNUM;
    logic [7:0]        TXDATA;
    logic              TXVALID;
    logic              TXREADY;
    logic [7:0]        RXDATA;
    logic              RXVALID;
    logic [BAUD_W-1:0] BAUDDIV;
    logic              TXEN, RXEN;
    logic [1:0]        PARITY;
    logic              TXINT, RXINT, TXOVRINT, RXOVRINT, UARTINT;

    uart_apb_regs_if apb();

    uart_apb_regs #(.FIFO_DEPTH(DEPTH), .BAUD_W(BAUD_W)) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .apb       (apb),
        .ECOREVNUM (ECOREVNUM),
        .TXDATA    (TXDATA),
        .TXVALID   (TXVALID),
        .TXREADY   (TXREADY),
        .RXDATA    (RXDATA),
        .RXVALID   (RXVALID),
        .BAUDDIV   (BAUDDIV),
        .TXEN      (TXEN),
        .RXEN      (RXEN),
        .PARITY    (PARITY),
        .TXINT     (TXINT),
        .RXINT     (RXINT),
        .TXOVRINT  (TXOVRINT),
        .RXOVRINT  (RXOVRINT),
        .UARTINT   (UARTINT)
    );

    always #5 PCLK = ~PCLK;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] rd_exp_q[$];
    logic [7:0]  tx_exp_q[$];
    logic [7:0]  rx_mdl_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input string tag, input logic [9:0] addr, input logic [31:0] data,
                             input logic exp_err);
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
        apb.PADDR = addr; apb.PWDATA = data;
        @(posedge PCLK); #1;
        apb.PENABLE = 1'b1;
        @(negedge PCLK);
        check({tag, "_rdy"}, 32'(apb.PREADY), 32'd1);
        check({tag, "_err"}, 32'(apb.PSLVERR), 32'(exp_err));
        @(posedge PCLK); #1;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    endtask

    task automatic apb_read(input string tag, input logic [9:0] addr, input logic [31:0] exp,
                            input logic exp_err);
        int          waits;
        logic [31:0] e;
        rd_exp_q.push_back(exp);
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = addr;
        @(posedge PCLK); #1;
        apb.PENABLE = 1'b1;
        waits = 0;
        @(negedge PCLK);
        while (!apb.PREADY && waits < 8) begin
            waits++;
            @(negedge PCLK);
        end
        check({tag, "_wait"}, 32'(waits), 32'd1);
        e = rd_exp_q.pop_front();
        check(tag, apb.PRDATA, e);
        check({tag, "_err"}, 32'(apb.PSLVERR), 32'(exp_err));
        @(posedge PCLK); #1;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    endtask

    task automatic tx_write(input logic [7:0] b, input logic txready_during);
        if (tx_exp_q.size() < DEPTH || txready_during) tx_exp_q.push_back(b);
        apb_write("wr_data", 10'h000, {24'h0, b}, 1'b0);
    endtask

    task automatic rx_strobe(input logic [7:0] b);
        @(posedge PCLK); #1;
        RXVALID = 1'b1; RXDATA = b;
        if (rx_mdl_q.size() < DEPTH) rx_mdl_q.push_back(b);
        @(posedge PCLK); #1;
        RXVALID = 1'b0;
    endtask

    task automatic rd_data(input string tag);
        logic [31:0] e;
        e = (rx_mdl_q.size() != 0) ? {24'h0, rx_mdl_q.pop_front()} : 32'h0;
        apb_read(tag, 10'h000, e, 1'b0);
    endtask

    initial begin
        logic [31:0] e;
        PRESET = 1'b1; ECOREVNUM = 4'h3; TXREADY = 1'b0; RXDATA = 8'h0; RXVALID = 1'b0;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = '0; apb.PWDATA = '0;
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b0;
        @(negedge PCLK);
        check("rst_pready", 32'(apb.PREADY), 32'd1);
        check("rst_pslverr", 32'(apb.PSLVERR), 32'd0);
        check("rst_prdata", apb.PRDATA, 32'd0);
        check("rst_txvalid", 32'(TXVALID), 32'd0);
        check("rst_uartint", 32'(UARTINT), 32'd0);
        check("rst_baud", 32'(BAUDDIV), 32'd0);
        @(posedge PCLK); #1;

        apb_write("wr_ctrl", 10'h002, 32'h03, 1'b0);
        apb_write("wr_baud", 10'h004, 32'h1D4C, 1'b0);
        apb_read("rd_ctrl", 10'h002, 32'h03, 1'b0);
        apb_read("rd_baud", 10'h004, 32'h1D4C, 1'b0);
        check("txen_rxen", {30'h0, RXEN, TXEN}, 32'h3);
        check("baud_out", 32'(BAUDDIV), 32'h1D4C);

        // TX fill with serialiser stalled: fifth byte overruns
        tx_write(8'h12, 1'b0); tx_write(8'h34, 1'b0); tx_write(8'h56, 1'b0);
        tx_write(8'h78, 1'b0); tx_write(8'h9A, 1'b0);
        apb_read("rd_status_txfull", 10'h001, 32'h01, 1'b0);
        apb_read("rd_intstat_txovr", 10'h003, 32'h4, 1'b0);
        check("txdata_head", {24'h0, TXDATA}, 32'h12);
        check("txvalid_full", 32'(TXVALID), 32'd1);

        TXREADY = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge PCLK);
            if (!TXVALID) break;
            e = (tx_exp_q.size() != 0) ? {24'h0, tx_exp_q.pop_front()} : 32'hDEAD_BEEF;
            check("tx_byte", {24'h0, TXDATA}, e);
        end
        check("tx_left", 32'(tx_exp_q.size()), 32'd0);
        @(posedge PCLK); #1;
        TXREADY = 1'b0;
        apb_read("rd_intstat_txdone", 10'h003, 32'h5, 1'b0);
        check("txint_masked", 32'(TXINT), 32'd0);

        apb_write("wr_ctrl_all", 10'h002, 32'h3F, 1'b0);
        @(posedge PCLK); #1;
        check("txint_en", {28'h0, RXOVRINT, TXOVRINT, RXINT, TXINT}, 32'h5);
        check("uartint_on", 32'(UARTINT), 32'd1);
        apb_write("wr_intclr", 10'h003, 32'hF, 1'b0);
        @(posedge PCLK); #1;
        check("uartint_off", 32'(UARTINT), 32'd0);

        // RX overrun: DEPTH+1 strobes
        for (int i = 0; i < DEPTH + 1; i++) rx_strobe(8'hA5);
        @(posedge PCLK); #1;
        check("rx_ints", {28'h0, RXOVRINT, TXOVRINT, RXINT, TXINT}, 32'hA);
        apb_read("rd_status_rxfull", 10'h001, 32'h4E, 1'b0);
        for (int i = 0; i < DEPTH + 1; i++) rd_data("rd_rx");
        apb_read("rd_intstat_rx", 10'h003, 32'hA, 1'b0);

        // W1C on INTSTAT racing an RX push: set wins for the rx bit
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
        apb.PADDR = 10'h003; apb.PWDATA = 32'hF;
        @(posedge PCLK); #1;
        apb.PENABLE = 1'b1; RXVALID = 1'b1; RXDATA = 8'h3C;
        rx_mdl_q.push_back(8'h3C);
        @(posedge PCLK); #1;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; RXVALID = 1'b0;
        @(posedge PCLK); #1;
        check("race_ints", {28'h0, RXOVRINT, TXOVRINT, RXINT, TXINT}, 32'h2);
        check("race_uartint", 32'(UARTINT), 32'd1);
        apb_read("rd_intstat_race", 10'h003, 32'h2, 1'b0);
        rd_data("rd_rx_race");
        apb_write("wr_intclr_rx", 10'h003, 32'h2, 1'b0);
        @(posedge PCLK); #1;
        check("uartint_clr", 32'(UARTINT), 32'd0);

        apb_write("wr_par_rsvd", 10'h005, 32'h3, 1'b0);
        check("parity_rsvd", 32'(PARITY), 32'd0);
        apb_write("wr_par_even", 10'h005, 32'h2, 1'b0);
        check("parity_even", 32'(PARITY), 32'd2);
        apb_read("rd_parity", 10'h005, 32'h2, 1'b0);

        apb_write("wr_baud_small", 10'h004, 32'h0F, 1'b1);
        apb_read("rd_baud_kept", 10'h004, 32'h1D4C, 1'b0);
        apb_write("wr_baud_min", 10'h004, 32'h10, 1'b0);
        check("baud_min", 32'(BAUDDIV), 32'h10);
        apb_read("rd_unmapped", 10'h006, 32'h0, 1'b1);
        apb_write("wr_unmapped", 10'h006, 32'hFF, 1'b1);
`ifdef UART_APB_REGS_ID_EN
        apb_read("rd_pid3", 10'h3FB, 32'h30, 1'b0);
        apb_write("wr_id", 10'h3F8, 32'hFF, 1'b0);
`else
        apb_read("rd_pid3", 10'h3FB, 32'h0, 1'b1);
        apb_write("wr_id", 10'h3F8, 32'hFF, 1'b1);
`endif

        // PSEL withdrawn during the wait cycle: no pop
        rx_strobe(8'h77);
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = 10'h000;
        @(posedge PCLK); #1;
        apb.PSEL = 1'b0;
        @(negedge PCLK);
        check("abandon_pready", 32'(apb.PREADY), 32'd1);
        @(posedge PCLK); #1;
        apb_read("rd_status_abandon", 10'h001, 32'h16, 1'b0);

        // Reset during a read wait state clears everything
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = 10'h000;
        @(posedge PCLK); #1;
        apb.PENABLE = 1'b1; PRESET = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0; apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
        rx_mdl_q.delete();
        @(negedge PCLK);
        check("midrst_pready", 32'(apb.PREADY), 32'd1);
        check("midrst_prdata", apb.PRDATA, 32'd0);
        @(posedge PCLK); #1;
        apb_read("rd_status_midrst", 10'h001, 32'h04, 1'b0);
        apb_read("rd_ctrl_midrst", 10'h002, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
